sd_multi_slot_loader: RTL and testbench
=======================================

Name: sd_multi_slot_loader

Overview:
Parametrised SD-card image loader serving NUM_SLOTS mounted images (CRT/PRG/ROM/TAP and further slots) to the core's ioctl download bus. Auto-loads a slot on mount, or on an explicit per-slot request. Buffers one sector internally and streams exactly img_size bytes, paced against ioctl_wait. Sits between the SD/OSD controller and the core's cartridge/tape/RAM loaders.

Parameters:
NUM_SLOTS, 5, number of image slots; one-hot width of rd/mount/request vectors
ADDR_W, 23, ioctl address width; maximum image size is 2^ADDR_W bytes
SECTOR_BYTES, 512, sector size; power of two
START_WAIT, 1508863, clk cycles of settle time before the first sector request
PACE, 32, minimum clk cycles between consecutive ioctl_wr pulses (>=2)

Ports:
clk  in  1  system clock
system_reset  in  1  asynchronous, active-high reset
sd_lba  out  32  sector address of the pending read
sd_rd  out  NUM_SLOTS  one-hot read request, cleared when sd_busy=1
sd_busy  in  1  SD controller accepted request
sd_byte_index  in  $clog2(SECTOR_BYTES)  byte index within the sector
sd_rd_data  in  8  SD read byte
sd_rd_byte_strobe  in  1  byte valid; written to buffer only while sd_busy=1
sd_done  in  1  sector complete
sd_img_mounted  in  NUM_SLOTS  per-slot mount strobe
sd_img_size  in  32  image size accompanying the mount strobe
load_req  in  NUM_SLOTS  per-slot reload request (pulse)
img_present  out  NUM_SLOTS  slot holds a non-empty image
load_active  out  NUM_SLOTS  one-hot slot currently loading
img_select  out  $clog2(NUM_SLOTS)  index of active/last slot
loader_busy  out  1  transfer in progress
load_error  out  1  sticky until next load start: oversize image or abort
ioctl_download  out  1  download window
ioctl_addr  out  ADDR_W  byte address
ioctl_data  out  8  byte data, valid while ioctl_wr=1
ioctl_wr  out  1  single-cycle write strobe
ioctl_wait  in  1  core back-pressure

Behaviour:
- Reset: all outputs 0; sizes cleared; pending flags cleared; state IDLE. Mid-transfer reset aborts immediately; ioctl_download drops asynchronously.
- Mount strobe on slot i: size_i<=sd_img_size; img_present[i]<=|sd_img_size. Non-zero size sets pending[i]. load_req[i] also sets pending[i] when img_present[i]=1.
- States: IDLE, ARM, WAIT_CORE, WAIT_SD, XFER, DONE.
- IDLE: select the lowest-index pending slot and clear its flag. If size > 2^ADDR_W: set load_error and stay IDLE. Otherwise go to ARM.
- ARM (1 cycle): loader_busy=1, load_active one-hot, ioctl_download=1, addr=0, sd_lba=0, load_error=0; timer=START_WAIT.
- WAIT_CORE: count timer to 0. At 0 with ioctl_wait=0: sd_rd<=onehot(slot); go to WAIT_SD.
- WAIT_SD: on sd_done go to XFER.
- XFER: emit byte per addr. ioctl_wr pulses only after >=PACE cycles since the previous pulse and ioctl_wait=0. ioctl_addr and ioctl_data are set in the same cycle as the pulse and held afterwards.
- XFER, sector exhausted: when addr reaches size: DONE. Else at the last byte of a sector: sd_lba+1, timer=1, WAIT_CORE.
- Exactly size bytes are written, last address = size-1. Partial final sector is truncated.
- Slot unmounted (size 0) while active: abort to DONE with load_error=1.
- DONE (1 cycle): ioctl_download=0, load_active=0, loader_busy=0, ioctl_addr=0; go to IDLE.
- Simultaneous mount/request on several slots: all set pending; service lowest index first, rest afterwards.
- Mount of the active slot during transfer: new size latched and pending re-set; current load completes with the old size, then reloads.
- Buffer read latency 1 cycle; the address is prefetched so data is ready at the pulse.

Optional Feature:
SD_LOADER_CHECKSUM_EN: adds output checksum[15:0].
- Modulo-2^16 sum of all bytes written in the current load.
- Cleared in ARM; valid from DONE until the next ARM.
- Without the macro: no port, no adder.

Test Plan:
- Mount slot 0 with size 1000, sector bytes 0..255 repeating -> sd_rd=00001 at lba 0 then lba 1; 1000 ioctl_wr pulses, addr 0..999, data=addr[7:0]; ioctl_download falls after addr 999.
- ioctl_wait held high 100 cycles mid-sector -> no ioctl_wr while high; no byte lost or duplicated; spacing >=PACE.
- Mount slots 3 and 1 in the same cycle -> slot 1 loads first, then slot 3; load_active 00010 then 01000.
- Mount with size 2^ADDR_W+1 -> load_error=1, no sd_rd, loader_busy stays 0.
- system_reset mid-XFER at addr 300 -> all outputs 0 next edge. Remount -> load restarts at addr 0, lba 0.
- load_req[0] after a completed load -> full reload. With checksum enabled, checksum matches the golden sum.

Source files
------------

// File: rtl/sd_multi_slot_loader_if.sv
// SD controller and ioctl download bus seen by sd_multi_slot_loader.
// master: loader side (drives SD requests and the ioctl stream).
// slave:  SD controller / core side.
interface sd_multi_slot_loader_if #(
    parameter int NUM_SLOTS    = 5,
    parameter int ADDR_W       = 23,
    parameter int SECTOR_BYTES = 512
);
    logic [31:0]                     sd_lba;
    logic [NUM_SLOTS-1:0]            sd_rd;
    logic                            sd_busy;
    logic [$clog2(SECTOR_BYTES)-1:0] sd_byte_index;
    logic [7:0]                      sd_rd_data;
    logic                            sd_rd_byte_strobe;
    logic                            sd_done;
    logic                            ioctl_download;
    logic [ADDR_W-1:0]               ioctl_addr;
    logic [7:0]                      ioctl_data;
    logic                            ioctl_wr;
    logic                            ioctl_wait;

    modport master (
        output sd_lba, sd_rd,
        input  sd_busy, sd_byte_index, sd_rd_data, sd_rd_byte_strobe, sd_done,
        output ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
        input  ioctl_wait
    );

    modport slave (
        input  sd_lba, sd_rd,
        output sd_busy, sd_byte_index, sd_rd_data, sd_rd_byte_strobe, sd_done,
        input  ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
        output ioctl_wait
    );
endinterface

// File: rtl/sd_multi_slot_loader.sv
// Multi-slot SD image loader: buffers one sector at a time and streams
// exactly img_size bytes of the selected slot onto the ioctl download bus.
// Optional feature macro: SD_LOADER_CHECKSUM_EN adds a 16-bit byte sum output.
module sd_multi_slot_loader #(
    parameter int NUM_SLOTS    = 5,
    parameter int ADDR_W       = 23,
    parameter int SECTOR_BYTES = 512,
    parameter int START_WAIT   = 1508863,
    parameter int PACE         = 32
) (
    input  logic                         clk,
    input  logic                         system_reset,
    sd_multi_slot_loader_if.master       bus,
    input  logic [NUM_SLOTS-1:0]         sd_img_mounted,
    input  logic [31:0]                  sd_img_size,
    input  logic [NUM_SLOTS-1:0]         load_req,
    output logic [NUM_SLOTS-1:0]         img_present,
    output logic [NUM_SLOTS-1:0]         load_active,
    output logic [$clog2(NUM_SLOTS)-1:0] img_select,
    output logic                         loader_busy,
    output logic                         load_error
`ifdef SD_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]                  checksum
`endif
);
    localparam int SEL_W  = $clog2(NUM_SLOTS);
    localparam int IDX_W  = $clog2(SECTOR_BYTES);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int TMR_W  = $clog2(START_WAIT + 2);
    localparam int PACE_W = $clog2(PACE + 1);
    localparam logic [32:0] MAX_SIZE = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_CORE, WAIT_SD, XFER, DONE} state_t;

    state_t               state, state_next;
    logic [31:0]          size_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] pending;
    logic [CNT_W-1:0]     active_size;
    logic [CNT_W-1:0]     addr_next;
    logic [TMR_W-1:0]     timer;
    logic [PACE_W-1:0]    pace_cnt;
    logic                 primed;
    logic [7:0]           mem [SECTOR_BYTES];
    logic [7:0]           buf_rd;

    logic                 sel_found;
    logic [SEL_W-1:0]     sel_idx;
    logic [31:0]          sel_size;
    logic                 aborted;
    logic                 pulse;
    logic                 last_byte;
    logic                 sector_end;

    // State register
    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) state <= IDLE;
        else              state <= state_next;
    end

    // Slot arbitration, write-pulse qualification and next-state decode
    always_comb begin
        state_next = state;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (pending[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = SEL_W'(i);
            end
        end
        sel_size   = size_q[sel_idx];
        aborted    = !img_present[img_select];
        // primed guarantees buf_rd was fetched for the current addr_next
        pulse      = (state == XFER) && primed && !bus.ioctl_wait &&
                     (pace_cnt >= PACE_W'(PACE)) && !aborted;
        last_byte  = (addr_next + CNT_W'(1)) == active_size;
        sector_end = &addr_next[IDX_W-1:0];
        case (state)
            IDLE:      if (sel_found && (sel_size != '0) && ({1'b0, sel_size} <= MAX_SIZE))
                           state_next = ARM;
            ARM:       state_next = WAIT_CORE;
            WAIT_CORE: if (aborted) state_next = DONE;
                       else if ((timer == '0) && !bus.ioctl_wait) state_next = WAIT_SD;
            WAIT_SD:   if (aborted) state_next = DONE;
                       else if (bus.sd_done) state_next = XFER;
            XFER:      if (aborted) state_next = DONE;
                       else if (pulse && last_byte) state_next = DONE;
                       else if (pulse && sector_end) state_next = WAIT_CORE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Slot bookkeeping, transfer datapath and registered outputs
    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) size_q[i] <= '0;
            pending            <= '0;
            img_present        <= '0;
            load_active        <= '0;
            img_select         <= '0;
            loader_busy        <= 1'b0;
            load_error         <= 1'b0;
            active_size        <= '0;
            addr_next          <= '0;
            timer              <= '0;
            pace_cnt           <= '0;
            primed             <= 1'b0;
            bus.sd_lba         <= '0;
            bus.sd_rd          <= '0;
            bus.ioctl_download <= 1'b0;
            bus.ioctl_addr     <= '0;
            bus.ioctl_data     <= '0;
            bus.ioctl_wr       <= 1'b0;
`ifdef SD_LOADER_CHECKSUM_EN
            checksum           <= '0;
`endif
        end else begin
            bus.ioctl_wr <= 1'b0;
            primed       <= (state == XFER) && !pulse;
            if (bus.sd_busy) bus.sd_rd <= '0;
            if (pace_cnt < PACE_W'(PACE)) pace_cnt <= pace_cnt + 1'b1;

            // Mount/request set pending after the IDLE claim so a same-cycle event re-arms the slot
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if ((state == IDLE) && sel_found && (sel_idx == SEL_W'(i))) pending[i] <= 1'b0;
                if (load_req[i] && img_present[i]) pending[i] <= 1'b1;
                if (sd_img_mounted[i]) begin
                    size_q[i]      <= sd_img_size;
                    img_present[i] <= |sd_img_size;
                    pending[i]     <= |sd_img_size;
                end
            end

            case (state)
                IDLE: if (sel_found) begin
                    img_select  <= sel_idx;
                    active_size <= CNT_W'(sel_size);
                    if ({1'b0, sel_size} > MAX_SIZE) load_error <= 1'b1;
                end
                ARM: begin
                    loader_busy        <= 1'b1;
                    load_active        <= NUM_SLOTS'(1) << img_select;
                    bus.ioctl_download <= 1'b1;
                    bus.ioctl_addr     <= '0;
                    bus.sd_lba         <= '0;
                    addr_next          <= '0;
                    load_error         <= 1'b0;
                    timer              <= TMR_W'(START_WAIT);
                    pace_cnt           <= PACE_W'(PACE);
`ifdef SD_LOADER_CHECKSUM_EN
                    checksum           <= '0;
`endif
                end
                WAIT_CORE: begin
                    if (aborted) load_error <= 1'b1;
                    else if (timer != '0) timer <= timer - 1'b1;
                    if (state_next == WAIT_SD) bus.sd_rd <= load_active;
                end
                WAIT_SD: if (aborted) load_error <= 1'b1;
                XFER: begin
                    if (aborted) load_error <= 1'b1;
                    if (pulse) begin
                        bus.ioctl_wr   <= 1'b1;
                        bus.ioctl_addr <= addr_next[ADDR_W-1:0];
                        bus.ioctl_data <= buf_rd;
                        addr_next      <= addr_next + CNT_W'(1);
                        pace_cnt       <= PACE_W'(1);
`ifdef SD_LOADER_CHECKSUM_EN
                        checksum       <= checksum + 16'(buf_rd);
`endif
                        if (sector_end && !last_byte) begin
                            bus.sd_lba <= bus.sd_lba + 32'd1;
                            timer      <= TMR_W'(1);
                        end
                    end
                end
                DONE: begin
                    bus.ioctl_download <= 1'b0;
                    bus.ioctl_addr     <= '0;
                    bus.sd_rd          <= '0;
                    load_active        <= '0;
                    loader_busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Sector buffer: SD side writes, loader side prefetches the next byte
    always_ff @(posedge clk) begin
        if (bus.sd_rd_byte_strobe && bus.sd_busy) mem[bus.sd_byte_index] <= bus.sd_rd_data;
        buf_rd <= mem[addr_next[IDX_W-1:0]];
    end
endmodule

// File: tb/tb_sd_multi_slot_loader.sv
// Scoreboard bench for sd_multi_slot_loader: stimulus queues the expected
// ioctl writes and SD sector requests; the SD model and ioctl monitor pop
// and compare them as the DUT produces them.
module tb_sd_multi_slot_loader;
    localparam int NS = 5;
    localparam int AW = 23;
    localparam int SB = 512;
    localparam int PACE = 4;

    typedef struct {
        logic [NS-1:0] act;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        logic [NS-1:0] rd;
        logic [31:0]   lba;
    } sd_req_t;

    logic          clk = 1'b0;
    logic          system_reset;
    logic [NS-1:0] sd_img_mounted;
    logic [31:0]   sd_img_size;
    logic [NS-1:0] load_req;
    logic [NS-1:0] img_present;
    logic [NS-1:0] load_active;
    logic [2:0]    img_select;
    logic          loader_busy;
    logic          load_error;
`ifdef SD_LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
    logic [15:0]   golden_sum;
`endif

    wr_t     exp_q[$];
    sd_req_t sd_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    sd_multi_slot_loader_if #(.NUM_SLOTS(NS), .ADDR_W(AW), .SECTOR_BYTES(SB)) bus ();

    sd_multi_slot_loader #(
        .NUM_SLOTS(NS), .ADDR_W(AW), .SECTOR_BYTES(SB), .START_WAIT(16), .PACE(PACE)
    ) dut (
        .clk(clk),
        .system_reset(system_reset),
        .bus(bus),
        .sd_img_mounted(sd_img_mounted),
        .sd_img_size(sd_img_size),
        .load_req(load_req),
        .img_present(img_present),
        .load_active(load_active),
        .img_select(img_select),
        .loader_busy(loader_busy),
        .load_error(load_error)
`ifdef SD_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sector byte j of image slot s at sector lba
    function automatic logic [7:0] pat(input int unsigned s, input int unsigned lba, input int unsigned j);
        return 8'(j) ^ 8'(lba * 32'h35) ^ 8'(s * 32'h11);
    endfunction

    task automatic push_load(input int unsigned slot, input int unsigned size);
        wr_t e;
        sd_req_t r;
`ifdef SD_LOADER_CHECKSUM_EN
        golden_sum = '0;
`endif
        for (int unsigned a = 0; a < size; a++) begin
            e.act  = NS'(1 << slot);
            e.addr = AW'(a);
            e.data = pat(slot, a / SB, a % SB);
            exp_q.push_back(e);
`ifdef SD_LOADER_CHECKSUM_EN
            golden_sum += 16'(e.data);
`endif
        end
        for (int unsigned l = 0; l <= (size - 1) / SB; l++) begin
            r.rd  = NS'(1 << slot);
            r.lba = l;
            sd_q.push_back(r);
        end
    endtask

    task automatic mount(input logic [NS-1:0] mask, input logic [31:0] size);
        sd_img_mounted = mask;
        sd_img_size    = size;
        @(posedge clk); #1;
        sd_img_mounted = '0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || loader_busy || bus.ioctl_download) && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_timeout"}, (n < 30000) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
        #1;
        check({name, "_sd_reqs_left"}, sd_q.size(), 0);
        check({name, "_wr_left"}, exp_q.size(), 0);
        check({name, "_download"}, bus.ioctl_download, 0);
        check({name, "_busy"}, loader_busy, 0);
    endtask

    task automatic wait_wr_addr(input string name, input int unsigned a);
        int unsigned n = 0;
        while (!(bus.ioctl_wr && bus.ioctl_addr == AW'(a)) && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_reach_addr"}, (n < 30000) ? 1 : 0, 1);
    endtask

    // SD controller model: answers each request with one sector and checks it
    initial begin : sd_model
        sd_req_t r;
        int unsigned s;
        int unsigned lba;
        bus.sd_busy = 1'b0;
        bus.sd_byte_index = '0;
        bus.sd_rd_data = '0;
        bus.sd_rd_byte_strobe = 1'b0;
        bus.sd_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.sd_rd != '0 && !system_reset) begin
                s = 0;
                for (int unsigned i = 0; i < NS; i++) if (bus.sd_rd[i]) s = i;
                if (sd_q.size() == 0) begin
                    check("sd_unexpected_rd", bus.sd_rd, 0);
                end else begin
                    r = sd_q.pop_front();
                    check("sd_rd", bus.sd_rd, r.rd);
                    check("sd_lba", bus.sd_lba, r.lba);
                end
                lba = bus.sd_lba;
                bus.sd_busy = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                for (int unsigned j = 0; j < SB; j++) begin
                    bus.sd_byte_index = 9'(j);
                    bus.sd_rd_data = pat(s, lba, j);
                    bus.sd_rd_byte_strobe = 1'b1;
                    @(posedge clk); #1;
                end
                bus.sd_rd_byte_strobe = 1'b0;
                bus.sd_done = 1'b1;
                @(posedge clk); #1;
                bus.sd_done = 1'b0;
                bus.sd_busy = 1'b0;
            end
        end
    end

    // ioctl monitor: pops the scoreboard on every write strobe
    initial begin : ioctl_monitor
        wr_t e;
        logic prev_wait = 1'b0;
        int unsigned since = 1000;
        forever begin
            @(negedge clk);
            if (system_reset) begin
                since = 1000;
                prev_wait = 1'b0;
            end else begin
                since++;
                if (bus.ioctl_wr) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr_addr", bus.ioctl_addr, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus.ioctl_addr, e.addr);
                        check("wr_data", bus.ioctl_data, e.data);
                        check("wr_load_active", load_active, e.act);
                        check("wr_download", bus.ioctl_download, 1);
                    end
                    check("wr_while_wait", prev_wait, 0);
                    check("wr_pace_ok", (since >= PACE) ? 1 : 0, 1);
                    since = 0;
                end
                prev_wait = bus.ioctl_wait;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : stimulus
        logic busy_seen;
        system_reset = 1'b1;
        sd_img_mounted = '0;
        sd_img_size = '0;
        load_req = '0;
        bus.ioctl_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        system_reset = 1'b0;
        @(posedge clk); #1;
        check("rst_img_present", img_present, 0);
        check("rst_load_active", load_active, 0);
        check("rst_busy", loader_busy, 0);
        check("rst_error", load_error, 0);
        check("rst_download", bus.ioctl_download, 0);
        check("rst_sd_rd", bus.sd_rd, 0);

        // Slot 0, 1000 bytes (two sectors), with back-pressure mid-sector
        push_load(0, 1000);
        mount(5'b00001, 1000);
        wait_wr_addr("t1", 100);
        bus.ioctl_wait = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        bus.ioctl_wait = 1'b0;
        wait_done("t1");
        check("t1_error", load_error, 0);

        // Slots 3 and 1 together: slot 1 first
        push_load(1, 600);
        push_load(3, 600);
        mount(5'b01010, 600);
        wait_done("t2");
        check("t2_img_select", img_select, 3);

        // Oversize image: error, no request, never busy
        mount(5'b00100, 32'h0080_0001);
        busy_seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | loader_busy | bus.ioctl_download;
        end
        check("t3_busy_seen", busy_seen, 0);
        check("t3_error", load_error, 1);
        check("t3_img_select", img_select, 2);
        check("t3_present", img_present, 5'b01111);

        // Reset at addr 300, then remount restarts from addr 0, lba 0
        push_load(4, 700);
        mount(5'b10000, 700);
        wait_wr_addr("t4", 300);
        system_reset = 1'b1;
        #1;
        check("t4_rst_download", bus.ioctl_download, 0);
        check("t4_rst_wr", bus.ioctl_wr, 0);
        check("t4_rst_addr", bus.ioctl_addr, 0);
        check("t4_rst_active", load_active, 0);
        check("t4_rst_busy", loader_busy, 0);
        check("t4_rst_present", img_present, 0);
        check("t4_rst_lba", bus.sd_lba, 0);
        exp_q.delete();
        sd_q.delete();
        repeat (3) @(posedge clk);
        #1;
        system_reset = 1'b0;
        @(posedge clk); #1;
        push_load(4, 700);
        mount(5'b10000, 700);
        wait_done("t4");

        // Slot 0 load, then reload via load_req
        push_load(0, 300);
        mount(5'b00001, 300);
        wait_done("t5a");
`ifdef SD_LOADER_CHECKSUM_EN
        check("t5a_checksum", checksum, golden_sum);
`endif
        push_load(0, 300);
        load_req = 5'b00001;
        @(posedge clk); #1;
        load_req = '0;
        wait_done("t5b");
`ifdef SD_LOADER_CHECKSUM_EN
        check("t5b_checksum", checksum, golden_sum);
`endif

        // Unmount during transfer aborts with error
        push_load(3, 51);
        mount(5'b01000, 400);
        wait_wr_addr("t6", 50);
        mount(5'b01000, 0);
        wait_done("t6");
        check("t6_error", load_error, 1);
        check("t6_present", img_present[3], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
